// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake and global stall.
// Define CLA_PIPE_FLAGS_EN to build the registered ovf/zero flags; otherwise they read 0.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW   = WIDTH / STAGES;
  localparam int NGRP = SW / BLOCK;

  if ((STAGES < 1) || (STAGES > 4) || ((WIDTH % (STAGES * BLOCK)) != 0)) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*BLOCK and STAGES must be 1..4");
  end

  // Per-group lookahead: each carry is a flat sum of generate/propagate products
  // off the group carry-in; groups themselves ripple within the slice.
  function automatic logic [SW:0] cla_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                          input logic ci);
    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [SW:0]   c;
    logic          term;
    logic          prod;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int grp = 0; grp < NGRP; grp++) begin
      for (int i = 1; i <= BLOCK; i++) begin
        term = c[grp*BLOCK];
        for (int m = 0; m < i; m++) term = term & p[grp*BLOCK+m];
        for (int m = 0; m < i; m++) begin
          prod = g[grp*BLOCK+m];
          for (int n = m + 1; n < i; n++) prod = prod & p[grp*BLOCK+n];
          term = term | prod;
        end
        c[grp*BLOCK+i] = term;
      end
    end
    return {c[SW], p ^ c[SW-1:0]};
  endfunction

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  always_comb begin
    b_eff = sub ? ~b : b;
    c0    = sub ? 1'b1 : cin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int AW = WIDTH - k * SW;
    logic [AW-1:0]       a_in;
    logic [AW-1:0]       b_in;
    logic                c_in;
    logic                v_in;
    logic [SW-1:0]       s_slice;
    logic [(k+1)*SW-1:0] s_d;
    logic [(k+1)*SW-1:0] s_q;
    logic                c_d;
    logic                c_q;
    logic                vld_d;
    logic                vld_q;

    // stage k input: ports for k=0, otherwise the previous stage registers
    if (k == 0) begin : g_head
      assign a_in = a;
      assign b_in = b_eff;
      assign c_in = c0;
      assign v_in = in_valid;
      assign s_d  = s_slice;
    end else begin : g_body
      assign a_in = g_stage[k-1].g_fwd.a_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].vld_q;
      assign s_d  = {s_slice, g_stage[k-1].s_q};
    end

    always_comb begin
      {c_d, s_slice} = cla_add(a_in[SW-1:0], b_in[SW-1:0], c_in);
      vld_d          = v_in;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)         vld_q <= 1'b0;
      else if (!stall) vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
      if (!stall) begin
        s_q <= s_d;
        c_q <= c_d;
      end
    end

    // upper operand slices not yet consumed travel to the next stage
    if (k < STAGES - 1) begin : g_fwd
      logic [AW-SW-1:0] a_d;
      logic [AW-SW-1:0] a_q;
      logic [AW-SW-1:0] b_d;
      logic [AW-SW-1:0] b_q;
      always_comb begin
        a_d = a_in[AW-1:SW];
        b_d = b_in[AW-1:SW];
      end
      always_ff @(posedge clk) begin
        if (!stall) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef CLA_PIPE_FLAGS_EN
    if (k == STAGES - 1) begin : g_tail
      logic ovf_d;
      logic ovf_q;
      logic zero_d;
      logic zero_q;
      always_comb begin
        ovf_d  = (a_in[AW-1] == b_in[AW-1]) & (s_d[WIDTH-1] != a_in[AW-1]);
        zero_d = (s_d == '0);
      end
      always_ff @(posedge clk) begin
        if (!stall) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
`endif
  end

  // output stage: data is only meaningful while out_valid, so it reads 0 otherwise
  assign out_valid = g_stage[STAGES-1].vld_q;
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign sum       = out_valid ? g_stage[STAGES-1].s_q : '0;
  assign cout      = out_valid & g_stage[STAGES-1].c_q;
`ifdef CLA_PIPE_FLAGS_EN
  assign ovf       = out_valid & g_stage[STAGES-1].g_tail.ovf_q;
  assign zero      = out_valid & g_stage[STAGES-1].g_tail.zero_q;
`else
  assign ovf       = 1'b0;
  assign zero      = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and table-driven bench for cla_pipe_adder: 32-bit/2-stage main instance
// plus 16-bit STAGES=1 and STAGES=4 instances for a random sweep.
module tb_cla_pipe_adder;

`ifdef CLA_PIPE_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] a, b, sum;

  logic        w_valid, w_cin, w_sub, w_ready;
  logic [15:0] w_a, w_b;
  logic        s1_in_ready, s1_valid, s1_cout, s1_ovf, s1_zero;
  logic [15:0] s1_sum;
  logic        s4_in_ready, s4_valid, s4_cout, s4_ovf, s4_zero;
  logic [15:0] s4_sum;

  int n_cmp = 0;
  int n_err = 0;

  cla_pipe_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero));

  cla_pipe_adder #(.WIDTH(16), .BLOCK(4), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(s1_in_ready), .a(w_a), .b(w_b),
    .cin(w_cin), .sub(w_sub), .out_valid(s1_valid), .out_ready(w_ready), .sum(s1_sum),
    .cout(s1_cout), .ovf(s1_ovf), .zero(s1_zero));

  cla_pipe_adder #(.WIDTH(16), .BLOCK(4), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(s4_in_ready), .a(w_a), .b(w_b),
    .cin(w_cin), .sub(w_sub), .out_valid(s4_valid), .out_ready(w_ready), .sum(s4_sum),
    .cout(s4_cout), .ovf(s4_ovf), .zero(s4_zero));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs [10];

  logic        hv  [0:1003];
  logic [15:0] ha  [0:1003];
  logic [15:0] hb  [0:1003];
  logic        hc  [0:1003];
  logic        hs  [0:1003];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic check_vec(input int i, input vec_t v);
    string nm;
    nm = $sformatf("vec%0d", i);
    @(posedge clk); #1;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, " early out_valid"}, 64'(out_valid), 64'(1'b0));
    @(negedge clk);
    chk({nm, " out_valid"}, 64'(out_valid), 64'(1'b1));
    chk({nm, " sum"},  64'(sum),  64'(v.s));
    chk({nm, " cout"}, 64'(cout), 64'(v.co));
    chk({nm, " ovf"},  64'(ovf),  64'(v.ov & FLAGS));
    chk({nm, " zero"}, 64'(zero), 64'(v.z & FLAGS));
  endtask

  task automatic stream(input string nm, input int n, input logic [31:0] abase, input logic ci,
                        input int st_at, input int st_len);
    int idx, got, first_c, last_c;
    logic [31:0] held;
    idx = 0; got = 0; first_c = -1; last_c = -1; held = '0;
    for (int cyc = 0; (cyc < n + st_len + 10) && (got < n); cyc++) begin
      @(posedge clk); #1;
      out_ready = !((cyc >= st_at) && (cyc < st_at + st_len));
      in_valid  = (idx < n);
      a = abase + 32'(idx); b = 32'(idx); cin = ci; sub = 1'b0;
      @(negedge clk);
      if (!out_ready) begin
        chk({nm, " stall out_valid"}, 64'(out_valid), 64'(1'b1));
        chk({nm, " stall in_ready"}, 64'(in_ready), 64'(1'b0));
        if (cyc == st_at) held = sum;
        else chk({nm, " stall sum hold"}, 64'(sum), 64'(held));
      end else begin
        chk({nm, " in_ready"}, 64'(in_ready), 64'(1'b1));
      end
      if (out_valid && out_ready) begin
        chk($sformatf("%s beat%0d sum", nm, got), 64'(sum), 64'(abase + 32'(2 * got) + 32'(ci)));
        got++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk({nm, " beats out"}, 64'(got), 64'(n));
    chk({nm, " output span"}, 64'(last_c - first_c), 64'(n - 1 + st_len));
  endtask

  task automatic check_w(input string nm, input int j, input logic ov, input logic [15:0] os,
                         input logic oc, input logic oo, input logic oz);
    logic        ev;
    logic [15:0] be;
    logic [16:0] full;
    logic        e_ovf;
    ev = (j >= 0) ? hv[j] : 1'b0;
    chk({nm, " out_valid"}, 64'(ov), 64'(ev));
    if (ev) begin
      be    = hs[j] ? ~hb[j] : hb[j];
      full  = {1'b0, ha[j]} + {1'b0, be} + 17'(hs[j] ? 1'b1 : hc[j]);
      e_ovf = (ha[j][15] == be[15]) && (full[15] != ha[j][15]);
      chk($sformatf("%s j%0d sum", nm, j), 64'(os), 64'(full[15:0]));
      chk($sformatf("%s j%0d cout", nm, j), 64'(oc), 64'(full[16]));
      chk($sformatf("%s j%0d ovf", nm, j), 64'(oo), 64'(e_ovf & FLAGS));
      chk($sformatf("%s j%0d zero", nm, j), 64'(oz), 64'((full[15:0] == 16'h0) & FLAGS));
    end
  endtask

  initial begin
    vecs[0] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0, 32'h1234_5679, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    w_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_sub = 1'b0; w_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'(1'b0));
    chk("reset sum", 64'(sum), 64'(32'h0));
    chk("reset cout", 64'(cout), 64'(1'b0));
    chk("reset ovf", 64'(ovf), 64'(1'b0));
    chk("reset zero", 64'(zero), 64'(1'b0));
    chk("reset in_ready", 64'(in_ready), 64'(1'b1));
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) check_vec(i, vecs[i]);

    stream("b2b", 8, 32'h0, 1'b1, 1000, 0);
    stream("bp", 8, 32'h100, 1'b0, 4, 3);

    // two beats in flight, then asynchronous reset between edges
    @(posedge clk); #1;
    a = 32'h11; b = 32'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h33; b = 32'h44;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre-reset out_valid", 64'(out_valid), 64'(1'b1));
    rst = 1'b1;
    #1;
    chk("mid reset out_valid", 64'(out_valid), 64'(1'b0));
    chk("mid reset sum", 64'(sum), 64'(32'h0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post reset no stale beat", 64'(out_valid), 64'(1'b0));
    check_vec(100, vecs[3]);

    for (int t = 0; t < 1004; t++) begin
      @(posedge clk); #1;
      if (t < 1000) begin
        w_valid = ($urandom_range(0, 3) != 0);
        w_a = 16'($urandom); w_b = 16'($urandom);
        w_cin = 1'($urandom); w_sub = 1'($urandom);
      end else begin
        w_valid = 1'b0;
      end
      hv[t] = w_valid; ha[t] = w_a; hb[t] = w_b; hc[t] = w_cin; hs[t] = w_sub;
      @(negedge clk);
      check_w("s1", t - 1, s1_valid, s1_sum, s1_cout, s1_ovf, s1_zero);
      check_w("s4", t - 4, s4_valid, s4_sum, s4_cout, s4_ovf, s4_zero);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the KGP-RISC datapath; successor to the fixed 32-bit combinational CLA.
- Operand width, lookahead group size and pipeline depth are configurable. Adds subtract mode and a valid/ready handshake with backpressure.
- Sits between the register-read stage and the writeback mux. Also serves as the adder for branch-target and address computation.

Parameters:
- WIDTH, 32, operand and sum width. Must be a multiple of STAGES*BLOCK.
- BLOCK, 4, CLA group size in bits. Generate/propagate are computed per group, carry is rippled between groups within a stage.
- STAGES, 2, number of pipeline register stages, 1..4. Each stage adds WIDTH/STAGES bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  adder can accept a beat
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  1 = compute a - b
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of the MSB (1 = no borrow when sub=1)
- ovf  out  1  signed overflow
- zero  out  1  sum == 0

Behaviour:
- Reset (async, rst=1): all stage valid bits cleared, so out_valid=0. sum, cout, ovf and zero read 0. in_ready=1 while rst is low and the pipe is not stalled.
- Effective operands: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1) adds bits [k*W/S +: W/S] using BLOCK-bit CLA groups.
  - The carry into stage k is the registered carry from stage k-1; stage 0 uses c0.
  - Upper-slice operands are carried forward in stage registers unchanged until their stage.
  - Lower-slice sums are carried forward unchanged once computed.
- Latency: an accepted beat (in_valid & in_ready) at edge N is presented on out_valid/sum in the cycle after edge N+STAGES-1. With STAGES=1, the result is registered and visible after the accepting edge.
- Throughput: one beat per cycle when out_ready=1.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, every stage register and valid bit holds, and the outputs stay stable.
  - Bubbles are not compressed during a stall (global stall).
- Ordering: results emerge in acceptance order. No reordering, no drop.
- Simultaneous accept at input and output in the same cycle: both occur and the pipe advances.
- in_valid=0 while not stalled: a bubble (valid=0) enters stage 0, and its data registers may update (don't-care).
- Arithmetic is modulo 2^WIDTH.
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB, i.e. (a_msb == b_eff_msb) & (sum_msb != a_msb).
- Reset asserted mid-operation: all in-flight beats are discarded immediately. After release, the first accepted beat follows normal latency.
- Illegal parameters (WIDTH % (STAGES*BLOCK) != 0, or STAGES outside 1..4) are reported by an elaboration-time $error.

Optional Feature:
- Macro: CLA_PIPE_FLAGS_EN.
- Defined: ovf and zero are computed in the final stage and registered alongside sum, with identical timing.
- Undefined: ovf and zero are tied to 0 and the flag logic is not built. Ports remain present. sum and cout are unaffected.

Test Plan:
- WIDTH=32, STAGES=2: a=0x8000_0000, b=0x8000_0000, cin=0, sub=0 -> after 2 cycles sum=0x0000_0000, cout=1, zero=1, ovf=1 (flags on).
- sub=1, a=5, b=7 -> sum=0xFFFF_FFFE, cout=0, ovf=0, zero=0. Then a=7, b=7, sub=1 -> sum=0, cout=1, zero=1.
- Back-to-back: 8 beats a=i, b=i, cin=1 with out_ready=1 -> sums 2i+1 in order on 8 consecutive cycles after latency; in_ready stays 1 throughout.
- Backpressure: out_ready=0 for 3 cycles with a result valid -> in_ready=0, sum/out_valid stable for 3 cycles; on release, no beat is lost or duplicated and order is preserved.
- Reset mid-flight: assert rst with 2 beats in the pipe -> out_valid=0 immediately. After release, a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, ovf=1.
- Parameter sweep: WIDTH=16, BLOCK=4, STAGES=1 and STAGES=4; 1000 random a/b/cin/sub -> output matches reference model (a ± b + c) mod 2^16, with latency equal to STAGES.
